// File: rtl/line_mem_unit.sv
// Line-buffer memory: writes raster rows into NM rotating banks, tracks which banks
// hold complete rows, and serves per-bank column reads to the controller.

module line_mem_bank #(
  parameter int XB = 10,
  parameter int PB = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [XB-1:0] waddr,
  input  logic [PB-1:0] wdata,
  input  logic [XB-1:0] raddr,
  output logic [PB-1:0] rdata
);
  logic [PB-1:0] ram [2**XB];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk)
    if (we) ram[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else      rdata <= ram[raddr];
endmodule

module line_mem_unit #(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8,
  parameter int NM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XB-1:0]          cfg_width,
  input  logic [YB-1:0]          cfg_height,
  input  logic                   in_valid,
  input  logic [PB-1:0]          in_data,
  output logic                   in_ready,
  input  logic [NM-1:0]          mem_used,
  input  logic [NM-1:0][XB-1:0]  mb_rd_addr,
  output logic [NM-1:0][PB-1:0]  pu_data,
  output logic [NM-1:0]          mb_full,
  output logic [NM-1:0]          mb_minfill,
  output logic                   frame_wr_done
);
  localparam int WBW = $clog2(NM);
  localparam int CW  = $clog2(NM + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_DONE} state_t;

  state_t         state;
  logic [XB-1:0]  wcol;
  logic [YB-1:0]  wrow;
  logic [WBW-1:0] wb, wb_nxt;
  logic [CW-1:0]  full_cnt, rel_cnt;
  logic [NM-1:0]  set_v, rel_v;
  logic           accept, last_col, last_row;

  assign in_ready = rst && !mb_full[wb] && (state == S_IDLE || state == S_FILL);
  assign accept   = in_valid && in_ready;
  assign last_col = (wcol == cfg_width - XB'(1));
  assign last_row = (wrow == cfg_height - YB'(1));
  assign wb_nxt   = (wb == WBW'(NM - 1)) ? '0 : wb + 1'b1;

  // A bank completed and released in the same cycle stays full.
  assign set_v = (accept && last_col) ? (NM'(1) << wb) : '0;
  assign rel_v = mem_used & mb_full & ~set_v;

  always_comb begin
    rel_cnt = '0;
    for (int i = 0; i < NM; i++) rel_cnt = rel_cnt + CW'(rel_v[i]);
  end

  for (genvar k = 0; k < NM; k++) begin : g_minfill
    assign mb_minfill[k] = (full_cnt >= CW'(k + 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      wcol          <= '0;
      wrow          <= '0;
      wb            <= '0;
      mb_full       <= '0;
      full_cnt      <= '0;
      frame_wr_done <= 1'b0;
    end else begin
      mb_full       <= (mb_full & ~rel_v) | set_v;
      full_cnt      <= full_cnt + CW'(|set_v) - rel_cnt;
      frame_wr_done <= 1'b0;
      if (accept) begin
        if (last_col) begin
          wcol <= '0;
          wb   <= wb_nxt;
          if (last_row) begin
            wrow          <= '0;
            state         <= S_DONE;
            frame_wr_done <= 1'b1;
          end else begin
            wrow  <= wrow + 1'b1;
            state <= mb_full[wb_nxt] ? S_WAIT : S_FILL;
          end
        end else begin
          wcol  <= wcol + 1'b1;
          state <= S_FILL;
        end
      end else begin
        case (state)
          S_WAIT:  if (!mb_full[wb]) state <= S_FILL;
          S_DONE:  state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NM; i++) begin : g_bank
    line_mem_bank #(.XB(XB), .PB(PB)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (accept && (wb == WBW'(i))),
      .waddr (wcol),
      .wdata (in_data),
      .raddr (mb_rd_addr[i]),
      .rdata (pu_data[i])
    );
  end
endmodule

// File: tb/tb_line_mem_unit.sv
// Directed bench for line_mem_unit: per-cycle vector table for a full frame, then
// hand sequences for back-pressure, set/release collisions, reads and mid-row reset.

module tb_line_mem_unit;
  localparam int XB = 10, YB = 10, PB = 8, NM = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [XB-1:0]         cfg_width;
  logic [YB-1:0]         cfg_height;
  logic                  in_valid;
  logic [PB-1:0]         in_data;
  logic                  in_ready;
  logic [NM-1:0]         mem_used;
  logic [NM-1:0][XB-1:0] mb_rd_addr;
  logic [NM-1:0][PB-1:0] pu_data;
  logic [NM-1:0]         mb_full;
  logic [NM-1:0]         mb_minfill;
  logic                  frame_wr_done;

  line_mem_unit #(.XB(XB), .YB(YB), .PB(PB), .NM(NM)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_used      (mem_used),
    .mb_rd_addr    (mb_rd_addr),
    .pu_data       (pu_data),
    .mb_full       (mb_full),
    .mb_minfill    (mb_minfill),
    .frame_wr_done (frame_wr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
    logic [3:0] used;
    logic       rdy;
    logic [3:0] full;
    logic [3:0] minfill;
    logic       done;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic vld, input logic [7:0] data, input logic [3:0] used,
                     input logic rdy, input logic [3:0] full, input logic [3:0] minfill,
                     input logic done);
    vec_t v;
    v.vld = vld; v.data = data; v.used = used; v.rdy = rdy;
    v.full = full; v.minfill = minfill; v.done = done;
    tv.push_back(v);
  endtask

  task automatic do_reset();
    step();
    in_valid = 1'b0; mem_used = '0; mb_rd_addr = '0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Stream n pixels back to back, data = base+index, checking in_ready each cycle.
  task automatic stream(input int n, input logic [7:0] base, input string name);
    for (int p = 0; p < n; p++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(p);
      #1 chk(name, in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    cfg_width = 10'd4; cfg_height = 10'd3;
    in_valid = 1'b0; in_data = '0; mem_used = '0; mb_rd_addr = '0;

    // Frame of 3 rows x 4 pixels, one vector per cycle starting right at reset release.
    //   vld  data   used    rdy  full     minfill  done
    add(1, 8'h01, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 8'h02, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 8'h03, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 8'h04, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 8'h05, 4'b0000, 1, 4'b0001, 4'b0001, 0);
    add(1, 8'h06, 4'b0000, 1, 4'b0001, 4'b0001, 0);
    add(1, 8'h07, 4'b0000, 1, 4'b0001, 4'b0001, 0);
    add(1, 8'h08, 4'b0000, 1, 4'b0001, 4'b0001, 0);
    add(1, 8'h09, 4'b0000, 1, 4'b0011, 4'b0011, 0);
    add(1, 8'h0A, 4'b0000, 1, 4'b0011, 4'b0011, 0);
    add(1, 8'h0B, 4'b0000, 1, 4'b0011, 4'b0011, 0);
    add(1, 8'h0C, 4'b0000, 1, 4'b0011, 4'b0011, 0);
    add(0, 8'h00, 4'b0000, 0, 4'b0111, 4'b0111, 1);
    add(0, 8'h00, 4'b0000, 1, 4'b0111, 4'b0111, 0);

    // Reset state
    step();
    step();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_full", mb_full, 4'b0000);
    chk("rst_minfill", mb_minfill, 4'b0000);
    chk("rst_done", frame_wr_done, 1'b0);
    chk("rst_pu", pu_data, 32'h0);
    step();
    rst = 1'b1;

    // Table-driven frame
    for (int i = 0; i < tv.size(); i++) begin
      in_valid = tv[i].vld; in_data = tv[i].data; mem_used = tv[i].used;
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, tv[i].rdy);
      chk($sformatf("v%0d_full", i), mb_full, tv[i].full);
      chk($sformatf("v%0d_minfill", i), mb_minfill, tv[i].minfill);
      chk($sformatf("v%0d_done", i), frame_wr_done, tv[i].done);
      step();
    end

    // Read latency: old address still reflected in the cycle the address changes
    mb_rd_addr[0] = 10'd0; mb_rd_addr[1] = 10'd2; mb_rd_addr[2] = 10'd3;
    #1 chk("rd_before", pu_data[1], 8'h05);
    step();
    chk("rd_b1", pu_data[1], 8'h07);
    chk("rd_b0", pu_data[0], 8'h01);
    chk("rd_b2", pu_data[2], 8'h0C);

    // Back-pressure: 4 rows fill every bank, FSM waits for a release
    cfg_height = 10'd8;
    do_reset();
    stream(16, 8'h10, "bp_ready");
    in_valid = 1'b1; in_data = 8'hA0;
    #1;
    chk("bp_wait_ready", in_ready, 1'b0);
    chk("bp_wait_full", mb_full, 4'b1111);
    chk("bp_wait_minfill", mb_minfill, 4'b1111);
    step();
    chk("bp_wait_ready2", in_ready, 1'b0);
    mem_used = 4'b0001;
    step();
    mem_used = 4'b0000;
    #1;
    chk("bp_rel_full", mb_full, 4'b1110);
    chk("bp_rel_ready", in_ready, 1'b0);
    chk("bp_rel_minfill", mb_minfill, 4'b0111);
    step();
    stream(4, 8'hA0, "bp_row5_ready");
    #1;
    chk("bp_row5_full", mb_full, 4'b1111);
    chk("bp_row5_stall", in_ready, 1'b0);
    mb_rd_addr[0] = 10'd1;
    step();
    chk("bp_row5_data", pu_data[0], 8'hA1);

    // Completion into bank 2 in the same cycle bank 0 is released
    do_reset();
    stream(11, 8'h30, "col_ready");
    in_valid = 1'b1; in_data = 8'h3B; mem_used = 4'b0001;
    #1;
    chk("col_pre_full", mb_full, 4'b0011);
    chk("col_pre_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; mem_used = 4'b0000;
    #1;
    chk("col_full", mb_full, 4'b0110);
    chk("col_minfill", mb_minfill, 4'b0011);

    // Release of an empty bank is ignored
    mem_used = 4'b1000;
    step();
    mem_used = 4'b0000;
    #1;
    chk("empty_rel_full", mb_full, 4'b0110);
    chk("empty_rel_minfill", mb_minfill, 4'b0011);

    // Two releases at once
    mem_used = 4'b0110;
    step();
    mem_used = 4'b0000;
    #1;
    chk("dual_rel_full", mb_full, 4'b0000);
    chk("dual_rel_minfill", mb_minfill, 4'b0000);

    // Reset mid-row (wcol=2, wrow=1)
    do_reset();
    stream(6, 8'h40, "mid_ready");
    mb_rd_addr[0] = 10'd0;
    #1 chk("mid_pre_full", mb_full, 4'b0001);
    step();
    chk("mid_pre_pu", pu_data[0], 8'h40);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_full", mb_full, 4'b0000);
    chk("mid_rst_minfill", mb_minfill, 4'b0000);
    chk("mid_rst_ready", in_ready, 1'b0);
    chk("mid_rst_pu", pu_data, 32'h0);
    chk("mid_rst_done", frame_wr_done, 1'b0);
    step();
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = 8'h55 + 8'(j);
      #1;
      chk($sformatf("mid_after_full%0d", j), mb_full, 4'b0000);
      chk($sformatf("mid_after_ready%0d", j), in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("mid_row_full", mb_full, 4'b0001);
    chk("mid_row_minfill", mb_minfill, 4'b0001);
    chk("mid_row_b0c0", pu_data[0], 8'h55);
    mb_rd_addr[0] = 10'd3;
    step();
    chk("mid_row_b0c3", pu_data[0], 8'h58);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
